// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store unit.
// Access-type codes match the core's macro.vh values.
package mem_access_unit_pkg;

    localparam logic [3:0] DT_W  = 4'd0;
    localparam logic [3:0] DT_HU = 4'd1;
    localparam logic [3:0] DT_H  = 4'd2;
    localparam logic [3:0] DT_BU = 4'd3;
    localparam logic [3:0] DT_B  = 4'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Unknown type codes fall back to word accesses.
    function automatic size_t access_size(input logic [3:0] data_type);
        access_size = SZ_WORD;
        case (data_type)
            DT_B, DT_BU: access_size = SZ_BYTE;
            DT_H, DT_HU: access_size = SZ_HALF;
            default:     access_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [3:0] data_type, input logic [1:0] addr_lo);
        misaligned = 1'b0;
        case (access_size(data_type))
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = |addr_lo;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [3:0] data_type, input logic [1:0] addr_lo);
        byte_enables = 4'b1111;
        case (access_size(data_type))
            SZ_BYTE: byte_enables = 4'b0001 << addr_lo;
            SZ_HALF: byte_enables = 4'b0011 << {addr_lo[1], 1'b0};
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [3:0] data_type, input logic [31:0] wdata);
        store_lanes = wdata;
        case (access_size(data_type))
            SZ_BYTE: store_lanes = {4{wdata[7:0]}};
            SZ_HALF: store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load-data lane select and sign/zero extension.
// Purely combinational: read word, low address bits and access type in, register-ready value out.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [3:0]  data_type,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (data_type)
            DT_B:    data = {{24{byte_lane[7]}}, byte_lane};
            DT_BU:   data = {24'h0, byte_lane};
            DT_H:    data = {{16{half_lane[15]}}, half_lane};
            DT_HU:   data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM requests into req/ack bus transactions,
// stalls the pipeline while a transfer is outstanding and flags address errors.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [3:0]        DataTypeM,
    input  logic [31:0]       ALUResM,
    input  logic [31:0]       WriteDataM,
    input  logic              ExcOccurM,
    input  logic              FlushM,
    input  logic              HoldM,
    output logic              StallM,
    output logic [31:0]       ReadDataM,
    output logic              ExcOccurLd,
    output logic [4:0]        ExcCodeLd,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack
);

    state_t      state;
    state_t      state_nxt;
    logic        request;
    logic        misalign;
    logic        access;
    logic        start;
    logic        flushed;
    logic        load_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  data_type_q;
    logic [31:0] ext_data;

    assign request  = MemtoRegM | MemWriteM;
    assign misalign = misaligned(DataTypeM, ALUResM[1:0]);
    assign access   = request & ~ExcOccurM & ~FlushM & ~misalign;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Stall and exception outputs are forced low while reset is held so the
    // hazard unit never sees a stall from an abandoned transaction.
    always_comb begin
        state_nxt  = state;
        StallM     = 1'b0;
        ExcOccurLd = 1'b0;
        ExcCodeLd  = '0;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    StallM    = 1'b1;
                    start     = 1'b1;
                    state_nxt = S_BUSY;
                end else if (request & ~ExcOccurM & ~FlushM & misalign) begin
                    ExcOccurLd = 1'b1;
                    ExcCodeLd  = MemtoRegM ? EXC_ADEL : EXC_ADES;
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                if (bus_ack) state_nxt = (flushed | FlushM) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (FlushM | ~HoldM) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!reset) begin
            StallM     = 1'b0;
            ExcOccurLd = 1'b0;
            ExcCodeLd  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            ReadDataM   <= '0;
            flushed     <= 1'b0;
            load_q      <= 1'b0;
            addr_lo_q   <= '0;
            data_type_q <= '0;
        end else begin
            if (start) begin
                bus_req     <= 1'b1;
                bus_we      <= MemWriteM & ~MemtoRegM;
                bus_addr    <= {ALUResM[ADDR_W-1:2], 2'b00};
                bus_be      <= byte_enables(DataTypeM, ALUResM[1:0]);
                bus_wdata   <= store_lanes(DataTypeM, WriteDataM);
                load_q      <= MemtoRegM;
                addr_lo_q   <= ALUResM[1:0];
                data_type_q <= DataTypeM;
                flushed     <= 1'b0;
            end
            if (state == S_BUSY) begin
                if (FlushM) flushed <= 1'b1;
                if (bus_ack) begin
                    bus_req <= 1'b0;
                    flushed <= 1'b0;
                    if (load_q & ~flushed & ~FlushM) ReadDataM <= ext_data;
                end
            end
        end
    end

    mem_access_unit_load_extend u_load_extend (
        .rdata     (bus_rdata),
        .addr_lo   (addr_lo_q),
        .data_type (data_type_q),
        .data      (ext_data)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores compared against an arithmetic model of lane/extend rules.
module tb_mem_access_unit;

    localparam int DT_W  = 0;
    localparam int DT_HU = 1;
    localparam int DT_H  = 2;
    localparam int DT_BU = 3;
    localparam int DT_B  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, MemWriteM, ExcOccurM, FlushM, HoldM;
    logic [3:0]  DataTypeM;
    logic [31:0] ALUResM, WriteDataM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        ExcOccurLd;
    logic [4:0]  ExcCodeLd;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata, bus_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .DataTypeM(DataTypeM),
        .ALUResM(ALUResM), .WriteDataM(WriteDataM), .ExcOccurM(ExcOccurM),
        .FlushM(FlushM), .HoldM(HoldM), .StallM(StallM), .ReadDataM(ReadDataM),
        .ExcOccurLd(ExcOccurLd), .ExcCodeLd(ExcCodeLd),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned model_size(input int dt);
        if (dt == DT_B || dt == DT_BU) return 1;
        if (dt == DT_H || dt == DT_HU) return 2;
        return 4;
    endfunction

    function automatic int unsigned model_off(input int dt, input logic [31:0] addr);
        int unsigned sz = model_size(dt);
        return ((addr % 4) / sz) * sz;
    endfunction

    function automatic logic [31:0] model_be(input int dt, input logic [31:0] addr);
        int unsigned sz = model_size(dt);
        return ((32'd1 << sz) - 1) << model_off(dt, addr);
    endfunction

    function automatic logic [31:0] model_wdata(input int dt, input logic [31:0] wd);
        int unsigned sz = model_size(dt);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input int dt, input logic [31:0] addr, input logic [31:0] rd);
        int unsigned sz = model_size(dt);
        logic [31:0] mask;
        logic [31:0] v;
        if (sz == 4) return rd;
        mask = (32'd1 << (8 * sz)) - 1;
        v = (rd >> (8 * model_off(dt, addr))) & mask;
        if ((dt == DT_B || dt == DT_H) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic clear_inputs();
        MemtoRegM = 1'b0; MemWriteM = 1'b0; DataTypeM = 4'd0;
        ALUResM = '0; WriteDataM = '0; ExcOccurM = 1'b0; FlushM = 1'b0;
    endtask

    // Issues one aligned access and plays a bus slave acking after `waits` cycles.
    task automatic run_access(input string tag, input bit ld, input int dt, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int waits);
        int stall = 0;
        int reqc = 0;
        bit done = 0;
        @(negedge clk);
        MemtoRegM = ld; MemWriteM = !ld; DataTypeM = 4'(dt); ALUResM = addr; WriteDataM = wd;
        for (int c = 0; c < 64; c++) begin
            bus_ack = 1'b0;
            if (bus_req) begin
                if (reqc == 0) begin
                    check({tag, ".addr"}, bus_addr, addr & ~32'd3);
                    check({tag, ".be"}, 32'(bus_be), model_be(dt, addr));
                    check({tag, ".we"}, 32'(bus_we), 32'(!ld));
                    if (!ld) check({tag, ".wdata"}, bus_wdata, model_wdata(dt, wd));
                end
                if (reqc == waits) begin
                    bus_ack = 1'b1;
                    bus_rdata = rd;
                end
                reqc++;
            end
            #1;
            if (!StallM) begin
                done = 1;
                break;
            end
            if (c > 0) check({tag, ".req_held"}, 32'(bus_req), 32'd1);
            stall++;
            @(negedge clk);
        end
        check({tag, ".complete"}, 32'(done), 32'd1);
        check({tag, ".stall_cycles"}, stall, waits + 2);
        check({tag, ".req_drop"}, 32'(bus_req), 32'd0);
        if (ld) check({tag, ".rdata"}, ReadDataM, model_load(dt, addr, rd));
        bus_rdata = $urandom;
        clear_inputs();
    endtask

    task automatic run_misalign(input string tag, input bit ld, input int dt, input logic [31:0] addr);
        @(negedge clk);
        MemtoRegM = ld; MemWriteM = !ld; DataTypeM = 4'(dt); ALUResM = addr; WriteDataM = $urandom;
        #1;
        check({tag, ".exc"}, 32'(ExcOccurLd), 32'd1);
        check({tag, ".code"}, 32'(ExcCodeLd), ld ? 32'd4 : 32'd5);
        check({tag, ".stall"}, 32'(StallM), 32'd0);
        @(negedge clk);
        #1;
        check({tag, ".no_req"}, 32'(bus_req), 32'd0);
        clear_inputs();
    endtask

    initial begin
        logic [31:0] held;
        reset = 1'b0; HoldM = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        clear_inputs();

        @(negedge clk);
        #1;
        check("rst.req", 32'(bus_req), 0);
        check("rst.we", 32'(bus_we), 0);
        check("rst.be", 32'(bus_be), 0);
        check("rst.addr", bus_addr, 0);
        check("rst.wdata", bus_wdata, 0);
        check("rst.rdata", ReadDataM, 0);
        check("rst.stall", 32'(StallM), 0);
        check("rst.exc", 32'(ExcOccurLd), 0);
        reset = 1'b1;

        run_access("lw100", 1, DT_W, 32'h100, 32'h0, 32'hDEADBEEF, 0);

        // Downstream hold in DONE must keep the result stable.
        HoldM = 1'b1;
        held = ReadDataM;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_rdata = $urandom;
            #1;
            check("hold.rdata", ReadDataM, held);
            check("hold.stall", 32'(StallM), 0);
        end
        HoldM = 1'b0;

        run_access("lb103", 1, DT_B, 32'h103, 32'h0, 32'h80A1B2C3, 1);
        run_access("lbu103", 1, DT_BU, 32'h103, 32'h0, 32'h80A1B2C3, 0);
        run_access("sh102", 0, DT_H, 32'h102, 32'h1234ABCD, 32'h0, 3);
        run_misalign("lw101", 1, DT_W, 32'h101);
        run_misalign("sh001", 0, DT_H, 32'h001);

        // Older exception pending: no access, no stall, no new exception.
        @(negedge clk);
        MemtoRegM = 1'b1; DataTypeM = 4'(DT_W); ALUResM = 32'h101; ExcOccurM = 1'b1;
        #1;
        check("excm.stall", 32'(StallM), 0);
        check("excm.exc", 32'(ExcOccurLd), 0);
        @(negedge clk);
        #1;
        check("excm.req", 32'(bus_req), 0);
        clear_inputs();

        // Flush one cycle into BUSY, ack two cycles later: no DONE, data discarded.
        held = ReadDataM;
        @(negedge clk);
        MemtoRegM = 1'b1; DataTypeM = 4'(DT_W); ALUResM = 32'h200;
        @(negedge clk);
        #1;
        check("flush.busy1_req", 32'(bus_req), 1);
        @(negedge clk);
        FlushM = 1'b1;
        #1;
        check("flush.busy2_stall", 32'(StallM), 1);
        @(negedge clk);
        FlushM = 1'b0;
        #1;
        check("flush.busy3_req", 32'(bus_req), 1);
        check("flush.busy3_stall", 32'(StallM), 1);
        @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        #1;
        check("flush.busy4_req", 32'(bus_req), 1);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("flush.idle_restall", 32'(StallM), 1);
        check("flush.req_drop", 32'(bus_req), 0);
        check("flush.discard", ReadDataM, held);
        MemtoRegM = 1'b0;
        #1;
        check("flush.idle", 32'(StallM), 0);

        // Reset asserted mid-transaction.
        @(negedge clk);
        MemtoRegM = 1'b1; DataTypeM = 4'(DT_W); ALUResM = 32'h300;
        @(negedge clk);
        #1;
        check("rstmid.req_busy", 32'(bus_req), 1);
        #1;
        reset = 1'b0;
        #1;
        check("rstmid.req", 32'(bus_req), 0);
        check("rstmid.stall", 32'(StallM), 0);
        check("rstmid.rdata", ReadDataM, 0);
        MemtoRegM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("rstmid.idle_req", 32'(bus_req), 0);
        MemtoRegM = 1'b1;
        #1;
        check("rstmid.idle_state", 32'(StallM), 1);
        MemtoRegM = 1'b0;

        for (int n = 0; n < 40; n++) begin
            int dt;
            int unsigned sz;
            bit ld;
            logic [31:0] addr;
            dt = int'($urandom_range(0, 4));
            ld = 1'($urandom);
            sz = model_size(dt);
            addr = $urandom & ~(sz - 1);
            if (sz > 1 && $urandom_range(0, 5) == 0) begin
                addr = addr | $urandom_range(1, sz - 1);
                run_misalign($sformatf("rnd%0d", n), ld, dt, addr);
            end else begin
                run_access($sformatf("rnd%0d", n), ld, dt, addr, $urandom, $urandom,
                           int'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
